// File: rtl/demux_xx2_strm.sv
// demux_xx2_strm: 1-to-4 valid/ready stream demux with a packet-locked lane select
module demux_xx2_strm #(
    parameter int WIDTH = 1,
    parameter int CNTW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_vld,
    output logic               i_rdy,
    input  logic [WIDTH-1:0]   i_dat,
    input  logic [1:0]         i_sel,
    input  logic               i_last,
    output logic [3:0]         o_vld,
    input  logic [3:0]         o_rdy,
    output logic [4*WIDTH-1:0] o_dat,
    output logic [3:0]         o_last,
    output logic               busy,
    output logic [1:0]         cur_sel,
    output logic [4*CNTW-1:0]  pkt_cnt
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [CNTW-1:0] ONE = CNTW'(1);
    state_t           r_state, w_next;
    logic [1:0]       r_sel, r_cur_sel, w_route;
    logic [3:0]       r_vld, r_last, w_acc, w_load;
    logic [WIDTH-1:0] r_dat [4];
    logic [CNTW-1:0]  r_cnt [4];
    logic             w_acpt, w_first;

    assign w_acc   = ~r_vld | o_rdy;
    assign w_route = (r_state == IDLE) ? i_sel : r_sel;
    assign i_rdy   = w_acc[w_route];
    assign w_acpt  = i_vld & i_rdy;
    assign o_vld   = r_vld;
    assign o_last  = r_last;
    assign cur_sel = r_cur_sel;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    // a packet is open after any accepted non-last beat and closes on an accepted last beat
    always_comb begin
        w_next = w_acpt ? (i_last ? IDLE : BUSY) : r_state;
    end

    // lane load strobe, first-beat flag and busy status
    always_comb begin
        w_load  = w_acpt ? 4'(4'd1 << w_route) : 4'd0;
        w_first = w_acpt && (r_state == IDLE);
        busy    = (r_state == BUSY);
    end

    // lock the lane on the first beat and count packets when their last beat is accepted
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_sel     <= 2'd0;
            r_cur_sel <= 2'd0;
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
        end else begin
            if (w_first) begin
                r_sel     <= i_sel;
                r_cur_sel <= i_sel;
            end
            if (w_acpt && i_last) r_cnt[w_route] <= r_cnt[w_route] + ONE;
        end

    // lane output registers; a load wins over a drain so a lane sustains one beat per cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_vld  <= 4'd0;
            r_last <= 4'd0;
            for (int k = 0; k < 4; k++) r_dat[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (w_load[k]) begin
                    r_vld[k]  <= 1'b1;
                    r_dat[k]  <= i_dat;
                    r_last[k] <= i_last;
                end else if (o_rdy[k]) begin
                    r_vld[k]  <= 1'b0;
                end
        end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign o_dat[k*WIDTH +: WIDTH]  = r_dat[k];
        assign pkt_cnt[k*CNTW +: CNTW]  = r_cnt[k];
    end
endmodule

// File: tb/tb_demux_xx2_strm.sv
// tb_demux_xx2_strm: directed and randomized checks of the 1-to-4 stream demux against a lane model
module tb_demux_xx2_strm;
    logic        clk = 1'b0, rst_n = 1'b0, i_vld = 1'b0, i_last = 1'b0;
    logic [7:0]  i_dat = 8'd0;
    logic [1:0]  i_sel = 2'd0;
    logic [3:0]  o_rdy = 4'd0;
    logic        i_rdy, busy, i_rdy2, busy2;
    logic [3:0]  o_vld, o_last, o_vld2, o_last2;
    logic [31:0] o_dat, o_dat2, pkt_cnt;
    logic [1:0]  cur_sel, cur_sel2;
    logic [7:0]  pkt_cnt2;
    int nvec = 0, nerr = 0;

    // reference model: one holding register per lane plus the open-packet lane
    logic [3:0]       m_vld, m_last;
    logic [3:0][7:0]  m_dat;
    logic             m_open;
    logic [1:0]       m_lane, m_cur;
    int               m_cnt [4];

    demux_xx2_strm #(.WIDTH(8), .CNTW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat), .i_sel(i_sel),
        .i_last(i_last), .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .o_last(o_last),
        .busy(busy), .cur_sel(cur_sel), .pkt_cnt(pkt_cnt));

    demux_xx2_strm #(.WIDTH(8), .CNTW(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_rdy(i_rdy2), .i_dat(i_dat), .i_sel(i_sel),
        .i_last(i_last), .o_vld(o_vld2), .o_rdy(o_rdy), .o_dat(o_dat2), .o_last(o_last2),
        .busy(busy2), .cur_sel(cur_sel2), .pkt_cnt(pkt_cnt2));

    always #5 clk = ~clk;

    function automatic logic [10:0] ectl();
        return {m_vld, m_last, m_open, m_cur};
    endfunction

    function automatic logic [31:0] ecnt8();
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(m_cnt[k]);
        return v;
    endfunction

    function automatic logic [7:0] ecnt2();
        logic [7:0] v;
        for (int k = 0; k < 4; k++) v[k*2 +: 2] = 2'(m_cnt[k]);
        return v;
    endfunction

    function automatic logic erdy();
        logic [1:0] r;
        r = m_open ? m_lane : i_sel;
        return !m_vld[r] || o_rdy[r];
    endfunction

    task automatic model_reset();
        m_vld = 4'd0; m_last = 4'd0; m_dat = '0; m_open = 1'b0; m_lane = 2'd0; m_cur = 2'd0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    endtask

    // advance one clock, applying the current inputs to the model at the edge
    task automatic step();
        logic       acc;
        logic [1:0] r;
        r   = m_open ? m_lane : i_sel;
        acc = i_vld && erdy();
        @(posedge clk);
        for (int k = 0; k < 4; k++)
            if (acc && r == 2'(k)) begin
                m_vld[k] = 1'b1; m_dat[k] = i_dat; m_last[k] = i_last;
            end else if (o_rdy[k]) m_vld[k] = 1'b0;
        if (acc) begin
            if (!m_open) m_cur = i_sel;
            if (i_last) begin m_cnt[r]++; m_open = 1'b0; end
            else begin m_open = 1'b1; m_lane = r; end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
        i_vld = v; i_sel = s; i_dat = d; i_last = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; drive(0, 0, 0, 0); o_rdy = 4'd0;
        #3;
        model_reset();
        nvec++;
        if (o_vld !== 4'd0 || o_last !== 4'd0 || o_dat !== 32'd0 || busy !== 1'b0 || cur_sel !== 2'd0 ||
            pkt_cnt !== 32'd0 || pkt_cnt2 !== 8'd0) begin
            nerr++;
            $display("FAIL reset_state: got vld=%h last=%h dat=%h busy=%b sel=%0d cnt=%h cnt2=%h, want all zero",
                     o_vld, o_last, o_dat, busy, cur_sel, pkt_cnt, pkt_cnt2);
        end
        rst_n = 1'b1;
        #1;
        nvec++;
        if (i_rdy !== 1'b1) begin nerr++; $display("FAIL reset_rdy: got %b want 1", i_rdy); end
    endtask

    task automatic test_three_beat();
        logic [7:0] d [3];
        d = '{8'h11, 8'h22, 8'h33};
        o_rdy = 4'hF;
        for (int i = 0; i < 3; i++) begin
            drive(1, 2, d[i], i == 2);
            #1;
            nvec++;
            if (i_rdy !== 1'b1) begin nerr++; $display("FAIL t2_rdy beat %0d: got %b want 1", i, i_rdy); end
            step();
            nvec++;
            if (o_vld !== 4'b0100 || o_dat[23:16] !== d[i] || o_last !== (i == 2 ? 4'b0100 : 4'b0000) ||
                busy !== (i < 2)) begin
                nerr++;
                $display("FAIL t2_beat %0d: got vld=%b dat=%h last=%b busy=%b want vld=0100 dat=%h last=%b busy=%b",
                         i, o_vld, o_dat[23:16], o_last, busy, d[i], (i == 2 ? 4'b0100 : 4'b0000), i < 2);
            end
        end
        drive(0, 2, 0, 0);
        step();
        nvec++;
        if (o_vld !== 4'd0 || pkt_cnt[23:16] !== 8'd1 || {o_vld, o_last, busy, cur_sel} !== ectl()) begin
            nerr++;
            $display("FAIL t2_done: got vld=%b cnt2=%0d ctl=%h want vld=0000 cnt2=1 ctl=%h",
                     o_vld, pkt_cnt[23:16], {o_vld, o_last, busy, cur_sel}, ectl());
        end
    endtask

    task automatic test_sel_lock();
        o_rdy = 4'hF;
        for (int i = 0; i < 4; i++) begin
            drive(1, i == 0 ? 2'd2 : 2'd1, 8'($urandom), i == 3);
            #1;
            nvec++;
            if (i_rdy !== erdy()) begin nerr++; $display("FAIL t3_rdy beat %0d: got %b want %b", i, i_rdy, erdy()); end
            step();
            nvec++;
            if (o_vld !== 4'b0100 || o_dat !== m_dat || {o_vld, o_last, busy, cur_sel} !== ectl()) begin
                nerr++;
                $display("FAIL t3_lock beat %0d: got vld=%b dat=%h ctl=%h want vld=0100 dat=%h ctl=%h",
                         i, o_vld, o_dat, {o_vld, o_last, busy, cur_sel}, m_dat, ectl());
            end
        end
        drive(0, 0, 0, 0);
        step();
    endtask

    task automatic test_stall();
        o_rdy = 4'b1110;
        drive(1, 0, 8'hAA, 1);
        #1;
        step();
        nvec++;
        if (o_vld !== 4'b0001 || o_dat[7:0] !== 8'hAA) begin
            nerr++; $display("FAIL t4_load: got vld=%b dat=%h want 0001 aa", o_vld, o_dat[7:0]);
        end
        drive(1, 0, 8'hBB, 1);
        #1;
        nvec++;
        if (i_rdy !== 1'b0) begin nerr++; $display("FAIL t4_block: got rdy=%b want 0", i_rdy); end
        step();
        nvec++;
        if (o_vld !== 4'b0001 || o_dat[7:0] !== 8'hAA) begin
            nerr++; $display("FAIL t4_hold: got vld=%b dat=%h want 0001 aa", o_vld, o_dat[7:0]);
        end
        i_sel = 2'd3;
        #1;
        nvec++;
        if (i_rdy !== 1'b1) begin nerr++; $display("FAIL t4_resel: got rdy=%b want 1", i_rdy); end
        step();
        nvec++;
        if (o_vld !== 4'b1001 || o_dat[31:24] !== 8'hBB || o_dat[7:0] !== 8'hAA || cur_sel !== 2'd3) begin
            nerr++;
            $display("FAIL t4_lane3: got vld=%b dat=%h sel=%0d want vld=1001 dat=bb....aa sel=3", o_vld, o_dat, cur_sel);
        end
        drive(0, 0, 0, 0);
        o_rdy = 4'hF;
        step();
        nvec++;
        if (o_vld !== 4'd0 || {o_vld, o_last, busy, cur_sel} !== ectl()) begin
            nerr++; $display("FAIL t4_drain: got ctl=%h want %h", {o_vld, o_last, busy, cur_sel}, ectl());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        o_rdy = 4'hF;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            drive(1, 1, d, i == 15);
            #1;
            nvec++;
            if (i_rdy !== 1'b1) begin nerr++; $display("FAIL t5_rdy beat %0d: got %b want 1", i, i_rdy); end
            step();
            nvec++;
            if (o_vld !== 4'b0010 || o_dat[15:8] !== d) begin
                nerr++; $display("FAIL t5_beat %0d: got vld=%b dat=%h want 0010 %h", i, o_vld, o_dat[15:8], d);
            end
        end
        drive(0, 0, 0, 0);
        step();
    endtask

    task automatic test_mid_reset();
        o_rdy = 4'hF;
        for (int i = 0; i < 2; i++) begin
            drive(1, 3, 8'($urandom), 0);
            #1;
            step();
        end
        nvec++;
        if (busy !== 1'b1 || o_vld !== 4'b1000) begin
            nerr++; $display("FAIL t6_open: got busy=%b vld=%b want 1 1000", busy, o_vld);
        end
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        #2;
        model_reset();
        nvec++;
        if (o_vld !== 4'd0 || busy !== 1'b0 || o_dat !== 32'd0 || pkt_cnt !== 32'd0) begin
            nerr++;
            $display("FAIL t6_reset: got vld=%b busy=%b dat=%h cnt=%h want zeros", o_vld, busy, o_dat, pkt_cnt);
        end
        rst_n = 1'b1;
        drive(1, 0, 8'h5A, 1);
        #1;
        step();
        nvec++;
        if (o_vld !== 4'b0001 || o_dat[7:0] !== 8'h5A || cur_sel !== 2'd0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL t6_after: got vld=%b dat=%h sel=%0d busy=%b want 0001 5a 0 0", o_vld, o_dat[7:0], cur_sel, busy);
        end
        drive(0, 0, 0, 0);
        step();
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
        o_rdy = 4'hF;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 8'(i), 1);
            #1;
            step();
        end
        drive(0, 0, 0, 0);
        nvec++;
        if (pkt_cnt2[3:2] !== 2'd1 || pkt_cnt[15:8] !== 8'd5) begin
            nerr++; $display("FAIL t7_wrap: got cnt2=%0d cnt8=%0d want 1 5", pkt_cnt2[3:2], pkt_cnt[15:8]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            o_rdy = 4'($urandom);
            drive($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
            #1;
            nvec++;
            if (i_rdy !== erdy() || i_rdy2 !== erdy()) begin
                nerr++; $display("FAIL rnd_rdy %0d: got %b/%b want %b", i, i_rdy, i_rdy2, erdy());
            end
            step();
            nvec++;
            if ({o_vld, o_last, busy, cur_sel} !== ectl()) begin
                nerr++; $display("FAIL rnd_ctl %0d: got %h want %h", i, {o_vld, o_last, busy, cur_sel}, ectl());
            end
            nvec++;
            if (o_dat !== m_dat) begin nerr++; $display("FAIL rnd_dat %0d: got %h want %h", i, o_dat, m_dat); end
            nvec++;
            if (pkt_cnt !== ecnt8() || pkt_cnt2 !== ecnt2()) begin
                nerr++;
                $display("FAIL rnd_cnt %0d: got %h/%h want %h/%h", i, pkt_cnt, pkt_cnt2, ecnt8(), ecnt2());
            end
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_three_beat();
        test_sel_lock();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
